// File: rtl/data_mem_responder.sv
// Word-addressed data-memory responder: one transaction at a time over valid/ready
// request and response channels, with a fixed number of wait states before each access.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             acc_write;
  logic [31:0]      acc_addr;
  logic [31:0]      acc_wdata;
  logic [3:0]       acc_be;
  logic [IDX_W-1:0] acc_idx;
  logic             acc_fault;
  logic             do_access;
  logic             mem_we;

  // With zero wait states the access happens on the accepting edge, so it must
  // see the live request rather than the copy being latched on that same edge.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
    acc_idx   = acc_addr[IDX_W+1:2];
    acc_fault = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    do_access = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_STATES == 0) begin
            do_access = 1'b1;
            state_d   = ST_RESP;
          end else begin
            cnt_d   = WAIT_LOAD;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (do_access) begin
      err_d   = acc_fault;
      rdata_d = (acc_fault || acc_write) ? 32'd0 : mem[acc_idx];
    end
  end

  // An edge while reset is held must never commit a store.
  assign mem_we = do_access && acc_write && !acc_fault && reset;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: storage has no reset so it maps onto plain RAM and survives reset pulses.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (2 and 0 wait states) driven by directed and
// random traffic, compared against a word-array model of the storage rules.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int NWORDS = 16;

  logic        clk = 1'b0;
  logic [1:0]  rst_n;
  logic [1:0]  req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic [31:0] rsp_rdata [2];

  int ws [2] = '{2, 0};
  logic [31:0] model [2][DEPTH];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic bit is_fault(input logic [31:0] addr);
    return (addr % 4 != 0) || (addr / 4 >= DEPTH);
  endfunction

  // Present a request, measure latency, sample the response, hold it for 'hold'
  // cycles of backpressure, then complete the handshake.
  task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input int hold,
                     output logic [31:0] rd, output logic er);
    int lat;
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
    req_wdata[d] = wd;   req_be[d] = be;
    for (int k = 0; k < 50 && !req_ready[d]; k++) @(negedge clk);
    check("req_ready_wait", 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid[d]) break;
    end
    check("latency", 32'(lat), 32'(ws[d] + 1));
    rd = rsp_rdata[d];
    er = rsp_err[d];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid[d]), 32'd1);
      check("hold_rdata", rsp_rdata[d], rd);
      check("hold_err",   32'(rsp_err[d]), 32'(er));
      check("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[d] = 1'b0;
    @(negedge clk);
    check("ready_after_rsp", 32'(req_ready[d]), 32'd1);
    check("valid_after_rsp", 32'(rsp_valid[d]), 32'd0);
  endtask

  task automatic txn_check(input string tag, input int d, input logic wr,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] be, input int hold);
    logic [31:0] rd, exp_rd;
    logic er, flt;
    flt = is_fault(addr);
    exp_rd = (flt || wr) ? 32'd0 : model[d][addr / 4];
    txn(d, wr, addr, wd, be, hold, rd, er);
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(er), 32'(flt));
    if (wr && !flt) model[d][addr / 4] = merge(model[d][addr / 4], wd, be);
  endtask

  task automatic do_reset(input int d);
    rst_n[d] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[d] = 1'b1;
  endtask

  initial begin
    logic [31:0] a, wd;
    logic wr;
    rst_n = 2'b00;
    req_valid = '0; req_write = '0; rsp_ready = '0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0; req_wdata[d] = '0; req_be[d] = '0;
      for (int w = 0; w < DEPTH; w++) model[d][w] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 2'b11;

    // Reset and idle.
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("idle_req_ready", 32'(req_ready[d]), 32'd1);
        check("idle_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        check("idle_rsp_err",   32'(rsp_err[d]),   32'd0);
        check("idle_rsp_rdata", rsp_rdata[d],      32'd0);
      end
    end

    // Give the model a known starting image.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < NWORDS; w++)
        txn_check("init", d, 1'b1, 32'(w * 4), $urandom, 4'b1111, 0);

    // Store/load and byte enables (2 wait states).
    txn_check("st_10", 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0);
    txn_check("ld_10", 0, 1'b0, 32'h10, 32'h0, 4'b0000, 0);
    check("ld_10_literal", model[0][4], 32'hDEADBEEF);
    txn_check("st_20a", 0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b1111, 0);
    txn_check("st_20b", 0, 1'b1, 32'h20, 32'h00000000, 4'b0101, 0);
    txn_check("ld_20",  0, 1'b0, 32'h20, 32'h0, 4'b1111, 0);
    txn_check("st_be0", 0, 1'b1, 32'h24, 32'h5A5A5A5A, 4'b0000, 0);
    txn_check("ld_24",  0, 1'b0, 32'h24, 32'h0, 4'b0000, 0);

    // Faults.
    txn_check("ld_misalign", 0, 1'b0, 32'h22, 32'h0, 4'b1111, 0);
    txn_check("st_oob", 0, 1'b1, 32'(4 * DEPTH), 32'h12345678, 4'b1111, 0);
    txn_check("st_misalign", 0, 1'b1, 32'h1, 32'h87654321, 4'b1111, 0);
    txn_check("ld_0", 0, 1'b0, 32'h0, 32'h0, 4'b0000, 0);

    // Backpressure (0 wait states) with an ignored request held during it.
    begin
      logic [31:0] rd;
      logic er;
      fork
        txn(1, 1'b0, 32'h8, 32'h0, 4'b0000, 5, rd, er);
        begin
          repeat (3) @(negedge clk);
          req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h14;
          req_wdata[1] = 32'hBADBADBA; req_be[1] = 4'b1111;
          repeat (2) @(negedge clk);
          req_valid[1] = 1'b0;
        end
      join
      check("bp_rdata", rd, model[1][2]);
      check("bp_err", 32'(er), 32'd0);
      txn_check("bp_ignored", 1, 1'b0, 32'h14, 32'h0, 4'b0000, 0);
    end

    // Back-to-back with rsp_ready already high (0 wait states).
    @(negedge clk);
    rsp_ready[1] = 1'b1; req_valid[1] = 1'b1; req_write[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_addr[1] = 32'(i * 4);
      check("b2b_idle_ready", 32'(req_ready[1]), 32'd1);
      check("b2b_idle_valid", 32'(rsp_valid[1]), 32'd0);
      @(negedge clk);
      check("b2b_rsp_valid", 32'(rsp_valid[1]), 32'd1);
      check("b2b_rsp_ready", 32'(req_ready[1]), 32'd0);
      check("b2b_rdata", rsp_rdata[1], model[1][i]);
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b0;

    // Reset during WAIT discards the pending store.
    txn_check("st_30", 0, 1'b1, 32'h30, 32'h11111111, 4'b1111, 0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h30;
    req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'b1111;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(posedge clk);
    #1 rst_n[0] = 1'b0;
    @(negedge clk);
    check("rst_wait_valid", 32'(rsp_valid[0]), 32'd0);
    rst_n[0] = 1'b1;
    @(negedge clk);
    check("rst_wait_ready", 32'(req_ready[0]), 32'd1);
    txn_check("ld_30", 0, 1'b0, 32'h30, 32'h0, 4'b0000, 0);
    check("ld_30_literal", model[0][12], 32'h11111111);

    // Reset during RESP keeps the committed store and drops the response.
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'h34;
    req_wdata[0] = 32'hA5A5A5A5; req_be[0] = 4'b1111;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_resp_pre_valid", 32'(rsp_valid[0]), 32'd1);
    do_reset(0);
    check("rst_resp_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_resp_rdata", rsp_rdata[0], 32'd0);
    model[0][13] = 32'hA5A5A5A5;
    txn_check("ld_34", 0, 1'b0, 32'h34, 32'h0, 4'b0000, 0);

    // Random traffic on both instances.
    for (int n = 0; n < 60; n++) begin
      int d;
      d = n % 2;
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 5))
        0:       a = 32'($urandom_range(0, NWORDS - 1) * 4 + $urandom_range(1, 3));
        1:       a = 32'(4 * DEPTH) + 32'($urandom_range(0, 4000));
        default: a = 32'($urandom_range(0, NWORDS - 1) * 4);
      endcase
      txn_check("rand", d, wr, a, wd, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
